// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: operation request in, status and result out.
interface seq_shifter_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
);
  logic             i_start;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_data1;
  logic [AMT_W-1:0] i_data2;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_output;

  modport master (
    output i_start, i_mode, i_data1, i_data2,
    input  o_busy, o_done, o_output
  );

  modport slave (
    input  i_start, i_mode, i_data1, i_data2,
    output o_busy, o_done, o_output
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the operand up to STEP bit positions per clock
// for SLL/SRL/SRA/ROR and publishes the result with a one-cycle DONE pulse.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int AMT_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  seq_shifter_if.slave  bus
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;
  localparam int XW = (AMT_W > CW) ? AMT_W : CW;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic [1:0]       r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [XW-1:0]    w_amtX;
  logic [CW-1:0]    w_effAmt;
  logic [CW-1:0]    w_step;
  logic [CW-1:0]    w_rorBack;
  logic [WIDTH-1:0] w_shifted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A new request is taken in IDLE and also in FIN, so a held START chains operations.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_next = FIN;
        end
      end
      FIN: begin
        w_done = 1'b1;
        if (bus.i_start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH since anything beyond is all fill.
  always_comb begin
    w_amtX = XW'(bus.i_data2);
    if (bus.i_mode == MODE_ROR) begin
      w_effAmt = CW'(w_amtX & XW'(WIDTH - 1));
    end else if (w_amtX >= XW'(WIDTH)) begin
      w_effAmt = CW'(WIDTH);
    end else begin
      w_effAmt = CW'(w_amtX);
    end

    w_step    = (r_cnt > CW'(STEP)) ? CW'(STEP) : r_cnt;
    w_rorBack = CW'(WIDTH) - w_step;

    case (r_mode)
      MODE_SLL: w_shifted = r_work << w_step;
      MODE_SRL: w_shifted = r_work >> w_step;
      MODE_SRA: w_shifted = $unsigned($signed(r_work) >>> w_step);
      MODE_ROR: w_shifted = (r_work >> w_step) | (r_work << w_rorBack);
      default:  w_shifted = r_work;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode   <= MODE_SLL;
      r_cnt    <= '0;
      r_work   <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mode <= bus.i_mode;
      r_cnt  <= w_effAmt;
      r_work <= bus.i_data1;
    end else if (r_state == RUN) begin
      if (r_cnt != '0) begin
        r_work <= w_shifted;
        r_cnt  <= r_cnt - w_step;
      end else begin
        r_result <= r_work;
      end
    end
  end

  assign bus.o_busy   = w_busy;
  assign bus.o_done   = w_done;
  assign bus.o_output = r_result;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: a STEP=1 and a STEP=4 instance checked against an
// arithmetic reference model with directed and randomized operations.
module tb_seq_shifter;

  localparam int LIMIT = 64;

  typedef struct {
    int         which;
    logic [1:0] m;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] res;
    int         lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errCount;
  int   checkCount;
  logic [7:0] lastRes [2];
  vec_t vecs [9];

  seq_shifter_if #(.WIDTH(8), .AMT_W(8)) busA ();
  seq_shifter_if #(.WIDTH(8), .AMT_W(8)) busB ();

  seq_shifter #(.WIDTH(8), .STEP(1), .AMT_W(8)) dutA (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (busA.slave)
  );

  seq_shifter #(.WIDTH(8), .STEP(4), .AMT_W(8)) dutB (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effAmt(input logic [1:0] m, input logic [7:0] d2);
    if (m == 2'b11) return int'(d2) % 8;
    return (int'(d2) > 8) ? 8 : int'(d2);
  endfunction

  // Reference: result from whole-word arithmetic on the effective amount.
  function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] d1,
                                       input logic [7:0] d2);
    int n;
    int r;
    int sd;
    n = effAmt(m, d2);
    r = int'(d1);
    case (m)
      2'b00: r = r << n;
      2'b01: r = r >> n;
      2'b10: begin
        sd = d1[7] ? r - 256 : r;
        r  = sd >>> n;
      end
      default: r = (r * 257) >> n;
    endcase
    return r[7:0];
  endfunction

  function automatic int modelLat(input int which, input logic [1:0] m, input logic [7:0] d2);
    int step;
    step = (which == 0) ? 1 : 4;
    return (effAmt(m, d2) + step - 1) / step + 1;
  endfunction

  task automatic setIn(input int which, input logic s, input logic [1:0] m,
                       input logic [7:0] d1, input logic [7:0] d2);
    if (which == 0) begin
      busA.i_start = s; busA.i_mode = m; busA.i_data1 = d1; busA.i_data2 = d2;
    end else begin
      busB.i_start = s; busB.i_mode = m; busB.i_data1 = d1; busB.i_data2 = d2;
    end
  endtask

  function automatic logic getBusy(input int which);
    return (which == 0) ? busA.o_busy : busB.o_busy;
  endfunction

  function automatic logic getDone(input int which);
    return (which == 0) ? busA.o_done : busB.o_done;
  endfunction

  function automatic logic [7:0] getOut(input int which);
    return (which == 0) ? busA.o_output : busB.o_output;
  endfunction

  // Issues one request, scrambles the don't-care inputs, then waits for DONE.
  task automatic runOp(input int which, input logic [1:0] m, input logic [7:0] d1,
                       input logic [7:0] d2, output logic [7:0] res, output int lat,
                       output logic busyAcc, output logic [7:0] outAcc);
    @(negedge clk);
    setIn(which, 1'b1, m, d1, d2);
    @(posedge clk);
    #1;
    busyAcc = getBusy(which);
    outAcc  = getOut(which);
    setIn(which, 1'b0, 2'($urandom), 8'($urandom), 8'($urandom));
    lat = 0;
    while (!getDone(which) && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = getOut(which);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setIn(0, 1'b1, 2'b00, 8'hFF, 8'd1);
    setIn(1, 1'b1, 2'b00, 8'hFF, 8'd1);
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      checkCount++;
      if (getBusy(w) !== 1'b0 || getDone(w) !== 1'b0 || getOut(w) !== 8'h00) begin
        errCount++;
        $display("[TB] FAIL reset_state dut%0d: busy=%b done=%b out=%h, want 0 0 00",
                 w, getBusy(w), getDone(w), getOut(w));
      end
    end
    @(negedge clk);
    setIn(0, 1'b0, 2'b00, 8'h00, 8'h00);
    setIn(1, 1'b0, 2'b00, 8'h00, 8'h00);
    rst_n = 1'b1;
    lastRes[0] = 8'h00;
    lastRes[1] = 8'h00;
  endtask

  task automatic test_vectors();
    logic [7:0] res;
    logic [7:0] outAcc;
    logic       busyAcc;
    int         lat;
    vecs[0] = '{0, 2'b11, 8'd136, 8'd3,  8'h11, 4};
    vecs[1] = '{0, 2'b10, 8'h88,  8'd2,  8'hE2, 3};
    vecs[2] = '{0, 2'b01, 8'h88,  8'd20, 8'h00, 9};
    vecs[3] = '{0, 2'b11, 8'h88,  8'd11, 8'h11, 4};
    vecs[4] = '{0, 2'b00, 8'h88,  8'd0,  8'h88, 1};
    vecs[5] = '{0, 2'b00, 8'hA5,  8'd8,  8'h00, 9};
    vecs[6] = '{0, 2'b10, 8'h88,  8'd8,  8'hFF, 9};
    vecs[7] = '{1, 2'b11, 8'h88,  8'd3,  8'h11, 2};
    vecs[8] = '{1, 2'b00, 8'h01,  8'd7,  8'h80, 3};
    for (int i = 0; i < 9; i++) begin
      runOp(vecs[i].which, vecs[i].m, vecs[i].d1, vecs[i].d2, res, lat, busyAcc, outAcc);
      checkCount++;
      if (res !== vecs[i].res || lat != vecs[i].lat) begin
        errCount++;
        $display("[TB] FAIL vector%0d: out=%h lat=%0d, want out=%h lat=%0d",
                 i, res, lat, vecs[i].res, vecs[i].lat);
      end
      checkCount++;
      if (busyAcc !== 1'b1 || outAcc !== lastRes[vecs[i].which]) begin
        errCount++;
        $display("[TB] FAIL vector%0d_accept: busy=%b out=%h, want busy=1 out=%h",
                 i, busyAcc, outAcc, lastRes[vecs[i].which]);
      end
      lastRes[vecs[i].which] = vecs[i].res;
    end
  endtask

  task automatic test_random();
    logic [7:0] res;
    logic [7:0] outAcc;
    logic [7:0] expRes;
    logic       busyAcc;
    logic [1:0] m;
    logic [7:0] d1;
    logic [7:0] d2;
    int         lat;
    int         w;
    for (int i = 0; i < 30; i++) begin
      w  = i % 2;
      m  = 2'($urandom);
      d1 = 8'($urandom);
      d2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      expRes = model(m, d1, d2);
      runOp(w, m, d1, d2, res, lat, busyAcc, outAcc);
      checkCount++;
      if (res !== expRes || lat != modelLat(w, m, d2) || outAcc !== lastRes[w]) begin
        errCount++;
        $display("[TB] FAIL random%0d dut%0d mode=%0d d1=%h d2=%0d: out=%h lat=%0d held=%h, want out=%h lat=%0d held=%h",
                 i, w, m, d1, d2, res, lat, outAcc, expRes, modelLat(w, m, d2), lastRes[w]);
      end
      lastRes[w] = expRes;
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    setIn(0, 1'b1, 2'b00, 8'h03, 8'd4);
    @(posedge clk);
    #1;
    @(negedge clk);
    setIn(0, 1'b1, 2'b01, 8'hFF, 8'd1);
    @(posedge clk);
    #1;
    lat = 1;
    checkCount++;
    if (getBusy(0) !== 1'b1 || getOut(0) !== lastRes[0]) begin
      errCount++;
      $display("[TB] FAIL ignore_start_run: busy=%b out=%h, want busy=1 out=%h",
               getBusy(0), getOut(0), lastRes[0]);
    end
    @(negedge clk);
    setIn(0, 1'b0, 2'b00, 8'h00, 8'h00);
    while (!getDone(0) && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkCount++;
    if (getOut(0) !== 8'h30 || lat != 5) begin
      errCount++;
      $display("[TB] FAIL ignore_start_result: out=%h lat=%0d, want out=30 lat=5", getOut(0), lat);
    end
    lastRes[0] = 8'h30;
    @(posedge clk);
    #1;
    checkCount++;
    if (getDone(0) !== 1'b0 || getOut(0) !== 8'h30) begin
      errCount++;
      $display("[TB] FAIL done_pulse: done=%b out=%h, want done=0 out=30", getDone(0), getOut(0));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    setIn(0, 1'b1, 2'b01, 8'hF0, 8'd2);
    @(posedge clk);
    #1;
    lat = 0;
    while (!getDone(0) && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkCount++;
    if (getOut(0) !== 8'h3C || lat != 3) begin
      errCount++;
      $display("[TB] FAIL b2b_first: out=%h lat=%0d, want out=3C lat=3", getOut(0), lat);
    end
    setIn(0, 1'b1, 2'b00, 8'h0F, 8'd3);
    @(posedge clk);
    #1;
    checkCount++;
    if (getBusy(0) !== 1'b1 || getDone(0) !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL b2b_no_idle: busy=%b done=%b, want busy=1 done=0", getBusy(0), getDone(0));
    end
    setIn(0, 1'b0, 2'b11, 8'h00, 8'h00);
    lat = 0;
    while (!getDone(0) && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkCount++;
    if (getOut(0) !== 8'h78 || lat != 4) begin
      errCount++;
      $display("[TB] FAIL b2b_second: out=%h lat=%0d, want out=78 lat=4", getOut(0), lat);
    end
    lastRes[0] = 8'h78;
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    logic [7:0] outAcc;
    logic       busyAcc;
    int         lat;
    int         doneSeen;
    @(negedge clk);
    setIn(0, 1'b1, 2'b00, 8'h01, 8'd6);
    @(posedge clk);
    #1;
    setIn(0, 1'b0, 2'b00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (getBusy(0) !== 1'b0 || getDone(0) !== 1'b0 || getOut(0) !== 8'h00) begin
      errCount++;
      $display("[TB] FAIL reset_mid_async: busy=%b done=%b out=%h, want 0 0 00",
               getBusy(0), getDone(0), getOut(0));
    end
    checkCount++;
    if (getOut(1) !== 8'h00) begin
      errCount++;
      $display("[TB] FAIL reset_mid_other: out=%h, want 00", getOut(1));
    end
    setIn(0, 1'b1, 2'b01, 8'hFF, 8'd1);
    @(posedge clk);
    #1;
    checkCount++;
    if (getBusy(0) !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_start_ignored: busy=%b, want 0", getBusy(0));
    end
    @(negedge clk);
    setIn(0, 1'b0, 2'b00, 8'h00, 8'h00);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (getDone(0) === 1'b1) doneSeen++;
    end
    checkCount++;
    if (doneSeen != 0) begin
      errCount++;
      $display("[TB] FAIL reset_no_done: done pulses=%0d, want 0", doneSeen);
    end
    lastRes[0] = 8'h00;
    lastRes[1] = 8'h00;
    runOp(0, 2'b10, 8'h80, 8'd3, res, lat, busyAcc, outAcc);
    checkCount++;
    if (res !== 8'hF0 || lat != 4 || busyAcc !== 1'b1 || outAcc !== 8'h00) begin
      errCount++;
      $display("[TB] FAIL reset_recover: out=%h lat=%0d busy=%b held=%h, want out=F0 lat=4 busy=1 held=00",
               res, lat, busyAcc, outAcc);
    end
    lastRes[0] = 8'hF0;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
